// File: rtl/dds_symbol_mod.sv
// Symbol-timed DDS modulator: phase accumulator, per-symbol latched controls,
// sine LUT and a two-stage output pipeline gated by en.
module dds_symbol_mod #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned LUT_AW  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [3:0]                mode,
  input  logic [1:0]                data,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic [PHASE_W-1:0]        fsk_phase_inc,
  input  logic [15:0]               sym_len,
  output logic signed [OUT_W-1:0]   wave,
  output logic                      valid,
  output logic                      sym_strobe
);

  typedef enum logic [3:0] {
    ModeSine   = 4'd0,
    ModeCos    = 4'd1,
    ModeSaw    = 4'd2,
    ModeSquare = 4'd3,
    ModeAsk    = 4'd8,
    ModeFsk    = 4'd9,
    ModeBpsk   = 4'd10,
    ModeRaw    = 4'd11,
    ModeQpsk   = 4'd12
  } mode_e;

  localparam real Pi = 3.14159265358979323846;
  localparam logic signed [OUT_W-1:0] MaxPos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MaxNeg = -MaxPos;

  // Elaboration-time sine via Taylor series on [-pi, pi], rounded to nearest.
  function automatic int lut_entry(int unsigned k);
    real x, term, s, r;
    x = 2.0 * Pi * real'(k) / real'(2 ** LUT_AW);
    if (x > Pi) x = x - 2.0 * Pi;
    term = x;
    s    = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    r = s * real'((2 ** (OUT_W - 1)) - 1);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  logic signed [OUT_W-1:0] lut [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    assign lut[k] = OUT_W'(lut_entry(k));
  end

  // Latched symbol controls and accumulator
  logic [PHASE_W-1:0] acc_q, acc_d, inc_q, fsk_q, inc_sel, offset, phase;
  logic [15:0]        cnt_q, cnt_d, len_q, len_eff;
  mode_e              mode_q;
  logic [1:0]         data_q;
  logic               latch;

  // Pipeline stage 1 and output stage
  logic [LUT_AW-1:0]       addr_q;
  logic [OUT_W-1:0]        top_q;
  mode_e                   s1_mode_q;
  logic                    s1_bit_q;
  logic signed [OUT_W-1:0] wave_q, wave_d, lut_val;
  logic                    fill_q, valid_q, strobe_q;

  always_comb begin
    latch   = (cnt_q == '0);
    inc_sel = (mode_q == ModeFsk) ? fsk_q : inc_q;
    len_eff = latch ? sym_len : len_q;
    cnt_d   = ((len_eff == '0) || (cnt_q == len_eff - 16'd1)) ? '0 : cnt_q + 16'd1;
    acc_d   = acc_q + inc_sel;
    case (mode_q)
      ModeCos:  offset = PHASE_W'(1) << (PHASE_W - 2);
      ModeBpsk: offset = PHASE_W'(data_q[0]) << (PHASE_W - 1);
      ModeQpsk: offset = (PHASE_W'(data_q) << (PHASE_W - 2)) | (PHASE_W'(1) << (PHASE_W - 3));
      default:  offset = '0;
    endcase
    phase = acc_q + offset;
  end

  always_comb begin
    lut_val = lut[addr_q];
    case (s1_mode_q)
      ModeSine, ModeCos, ModeFsk, ModeBpsk, ModeQpsk: wave_d = lut_val;
      ModeAsk:    wave_d = s1_bit_q ? lut_val : '0;
      ModeSaw:    wave_d = {~top_q[OUT_W-1], top_q[OUT_W-2:0]};
      ModeSquare: wave_d = top_q[OUT_W-1] ? MaxNeg : MaxPos;
      ModeRaw:    wave_d = s1_bit_q ? MaxPos : MaxNeg;
      default:    wave_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= ModeSine;
      data_q    <= '0;
      inc_q     <= '0;
      fsk_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      top_q     <= '0;
      s1_mode_q <= ModeSine;
      s1_bit_q  <= 1'b0;
      wave_q    <= '0;
      fill_q    <= 1'b0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (en) begin
        // Stage 1 snapshots the pre-update accumulator and symbol controls
        addr_q    <= phase[PHASE_W-1 -: LUT_AW];
        top_q     <= acc_q[PHASE_W-1 -: OUT_W];
        s1_mode_q <= mode_q;
        s1_bit_q  <= data_q[0];
        wave_q    <= wave_d;
        fill_q    <= 1'b1;
        valid_q   <= fill_q;
        strobe_q  <= latch;
        acc_q     <= acc_d;
        cnt_q     <= cnt_d;
        if (latch) begin
          mode_q <= mode_e'(mode);
          data_q <= data;
          inc_q  <= phase_inc;
          fsk_q  <= fsk_phase_inc;
          len_q  <= sym_len;
        end
      end
    end
  end

  assign wave       = wave_q;
  assign valid      = valid_q;
  assign sym_strobe = strobe_q;

endmodule

// File: doc/dds_symbol_mod.md
DDS_SYMBOL_MOD -- requirements
Module: dds_symbol_mod

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
REQ-002 SHALL have parameter OUT_W, default 12: signed output width.
REQ-003 SHALL have parameter LUT_AW, default 8: sine LUT address width, full cycle, 2^LUT_AW entries.
REQ-004 SHALL have port clk  in  1: sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port en  in  1: advance enable.
REQ-007 SHALL have port mode  in  4: 0 SINE, 1 COSINE, 2 SAW, 3 SQUARE, 8 ASK, 9 FSK, 10 BPSK, 11 RAW, 12 QPSK.
REQ-008 SHALL have port data  in  2: symbol data.
REQ-009 SHALL have port phase_inc  in  PHASE_W: carrier increment.
REQ-010 SHALL have port fsk_phase_inc  in  PHASE_W: increment used in FSK mode.
REQ-011 SHALL have port sym_len  in  16: symbol length in en cycles.
REQ-012 SHALL have port wave  out  OUT_W, signed: registered sample.
REQ-013 SHALL have port valid  out  1: wave carries pipeline data.
REQ-014 SHALL have port sym_strobe  out  1: one-cycle pulse at each symbol latch.

Function
REQ-015 SHALL hold all state (accumulator, symbol counter, pipeline, outputs) unchanged in any cycle with en=0; sym_strobe SHALL be 0 in such cycles.
REQ-016 SHALL keep symbol counter cnt; on an en cycle with cnt==0, latch mode, data, phase_inc, fsk_phase_inc, sym_len; sym_strobe=1 the following cycle.
REQ-017 SHALL advance cnt each en cycle to 0 when cnt==L-1, else cnt+1; L = latched sym_len, with 0 treated as 1 (latch every en cycle).
REQ-018 SHALL ignore input changes between latches; mode/data changes take effect only at the next latch.
REQ-019 SHALL add, each en cycle, increment inc to acc modulo 2^PHASE_W; inc = latched fsk_phase_inc in FSK, else latched phase_inc; a newly latched inc first applies on the en cycle after the latch.
REQ-020 SHALL form phase p = acc + offset (mod 2^PHASE_W); offset: COSINE 2^(PHASE_W-2); BPSK data[0]*2^(PHASE_W-1); QPSK data*2^(PHASE_W-2) + 2^(PHASE_W-3); all others 0.
REQ-021 SHALL address LUT with p[PHASE_W-1 -: LUT_AW]; LUT[k] = round((2^(OUT_W-1)-1)*sin(2*pi*k/2^LUT_AW)).
REQ-022 SHALL map output: SINE/COSINE/FSK/BPSK/QPSK = LUT; ASK = LUT if data[0] else 0; SAW = {~acc[MSB], acc[MSB-1 -: OUT_W-1]}; SQUARE = +M if acc[MSB]==0 else -M; RAW = +M if data[0] else -M; M = 2^(OUT_W-1)-1; undefined modes = 0.
REQ-023 SHALL use a 2-stage pipeline: wave reflects acc/latched mode/data of two en cycles earlier.
REQ-024 SHALL assert valid once two en cycles have passed after reset; valid stays 1 until reset.
REQ-025 SHALL give rst priority over en in the same cycle.

Reset
REQ-026 SHALL on rst=1 set acc=0, cnt=0, latched mode=SINE, data=0, incs=0, sym_len=0, pipeline=0, wave=0, valid=0, sym_strobe=0.
REQ-027 SHALL discard the current symbol on mid-symbol reset; first en cycle after release performs a latch.

Verification (PHASE_W=32, OUT_W=12, LUT_AW=8)
REQ-028 SHALL cover reset: rst 3 cycles with en=1 -> wave=0, valid=0, sym_strobe=0; after release sym_strobe=1 on 2nd cycle, valid=1 from 3rd.
REQ-029 SHALL cover SINE, phase_inc=2^24, sym_len=0 -> wave 0,50,100,... ; 2047 at sample 64, -2047 at 192, period 256; COSINE starts at 2047.
REQ-030 SHALL cover QPSK, phase_inc=0, data 0/1/2/3 -> wave 1447/1447/-1447/-1447; BPSK data=1 -> 0; RAW data 1/0 -> 2047/-2047.
REQ-031 SHALL cover symbol alignment: sym_len=10, mode SINE->SQUARE mid-symbol -> sym_strobe every 10 en cycles, wave switches exactly 2 en cycles after next strobe.
REQ-032 SHALL cover en gating: en=0 for 5 cycles mid-sine -> wave/cnt frozen, resumes with next sample, no skip.
REQ-033 SHALL cover FSK/wrap: fsk_phase_inc 71582789 vs 14316558 -> period 60 vs 300 samples; phase_inc=0xFFFFFFFF SAW -> descending ramp, wraps -2048 to 2047.
